// File: rtl/gcd_sched_pkg.sv
// Shared types and defaults for the gcd request scheduler and its arbiter.
package gcd_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_e;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 8;
   localparam int IDW_DEF  = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

   // Requester-index width; a lone requester still needs a 1-bit id field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gcd_scheduler_rr_arbiter.sv
// Round-robin arbiter: the requester at ptr_i has top priority, then ptr_i+1, wrapping.
module rr_arbiter
   import gcd_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o,
   output logic            gnt_any_o
);

   logic [2*NREQ-1:0] req2;
   logic [2*NREQ-1:0] gnt2;

   // Doubling the request vector turns the wrap-around search into a linear window [ptr, ptr+NREQ).
   always_comb begin
      int   p;
      logic hit;
      p    = int'(ptr_i);
      hit  = 1'b0;
      gnt2 = '0;
      req2 = {req_i, req_i};
      for (int i = 0; i < 2*NREQ; i++) begin
         if (!hit && (i >= p) && (i < p + NREQ) && req2[i]) begin
            gnt2[i] = 1'b1;
            hit     = 1'b1;
         end
      end
      gnt_o     = gnt2[NREQ-1:0] | gnt2[2*NREQ-1:NREQ];
      gnt_any_o = hit;
      gnt_idx_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_o[k]) gnt_idx_o = IDW'(k);
      end
   end

endmodule

// File: rtl/gcd_scheduler.sv
// Time-shares one gcd core among NREQ requesters with a single operand pair in flight;
// pairs containing a zero operand are answered directly without touching the core.
module gcd_scheduler
   import gcd_sched_pkg::*;
#(
   parameter int  NREQ = NREQ_DEF,
   parameter int  DW   = DW_DEF,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  i_req_valid,
   input  logic [NREQ*DW-1:0] i_req_a,
   input  logic [NREQ*DW-1:0] i_req_b,
   output logic [NREQ-1:0]  o_req_ready,
   output logic [DW-1:0]    o_core_a,
   output logic [DW-1:0]    o_core_b,
   output logic             o_core_valid,
   input  logic             i_core_ready,
   input  logic [DW-1:0]    i_core_gcd,
   input  logic             i_core_valid,
   output logic             o_core_ready,
   output logic [DW-1:0]    o_rsp_gcd,
   output logic [IDW-1:0]   o_rsp_id,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [15:0]      o_done_cnt
);

   sched_state_e   state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [DW-1:0]  a_q, a_d;
   logic [DW-1:0]  b_q, b_d;
   logic [IDW-1:0] id_q, id_d;
   logic [DW-1:0]  gcd_q, gcd_d;
   logic [15:0]    done_cnt_q, done_cnt_d;

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   logic [DW-1:0]   win_a, win_b;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i     (i_req_valid),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            win_a = i_req_a[k*DW +: DW];
            win_b = i_req_b[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      gcd_d       = gcd_q;
      done_cnt_d  = done_cnt_q;
      o_req_ready = '0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               o_req_ready = gnt;
               a_d         = win_a;
               b_d         = win_b;
               id_d        = gnt_idx;
               ptr_d       = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
               // gcd(x,0) = x and gcd(0,0) = 0, so A|B is the answer whenever either side is zero.
               if (win_a == '0 || win_b == '0) begin
                  gcd_d   = win_a | win_b;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (i_core_ready) state_d = WAIT;
         end
         WAIT: begin
            if (i_core_valid) begin
               gcd_d   = i_core_gcd;
               state_d = RESP;
            end
         end
         RESP: begin
            if (i_rsp_ready) begin
               state_d    = IDLE;
               done_cnt_d = done_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) o_req_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         gcd_q      <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         gcd_q      <= gcd_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign o_core_valid = (state_q == ISSUE);
   assign o_core_ready = (state_q == WAIT);
   assign o_rsp_valid  = (state_q == RESP);
   assign o_core_a     = a_q;
   assign o_core_b     = b_q;
   assign o_rsp_gcd    = gcd_q;
   assign o_rsp_id     = id_q;
   assign o_done_cnt   = done_cnt_q;

endmodule

// File: doc/gcd_scheduler.md
GCD_SCHEDULER -- requirements
Module: gcd_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one gcd core.
REQ-002 Parameter DW, default 8, operand/result width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 i_req_a  input  NREQ*DW  operand A, requester k at bits [k*DW +: DW].
REQ-007 i_req_b  input  NREQ*DW  operand B, same packing as i_req_a.
REQ-008 o_req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-009 o_core_a, o_core_b  output  DW each  operands to gcd core.
REQ-010 o_core_valid  output  1  operand valid to core; i_core_ready  input  1  core accepts operands.
REQ-011 i_core_gcd  input  DW  core result; i_core_valid  input  1  result valid; o_core_ready  output  1  scheduler accepts result.
REQ-012 o_rsp_gcd  output  DW  result; o_rsp_id  output  clog2(NREQ)  originating requester; o_rsp_valid  output  1; i_rsp_ready  input  1.
REQ-013 o_done_cnt  output  16  count of completed responses.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-015 IDLE: if any i_req_valid is set, the round-robin winner g SHALL see o_req_ready[g]=1 that same cycle; operands and ID are captured at that edge; o_req_ready is 0 in all other states.
REQ-016 Priority: after a grant to g, highest priority SHALL be (g+1) mod NREQ; after reset, requester 0 has highest priority.
REQ-017 Zero bypass: if captured A==0 or B==0, the FSM SHALL go IDLE->RESP with result A|B (gcd(0,0)=0), with no core transaction.
REQ-018 Otherwise IDLE->ISSUE; ISSUE drives o_core_valid=1 with registered operands and moves to WAIT on the edge where i_core_ready=1.
REQ-019 WAIT: o_core_ready=1; on i_core_valid=1, i_core_gcd SHALL be registered and the FSM moves to RESP.
REQ-020 RESP: o_rsp_valid=1 with stable o_rsp_gcd and o_rsp_id until i_rsp_ready=1; that edge returns to IDLE and increments o_done_cnt.
REQ-021 o_done_cnt SHALL wrap from 0xFFFF to 0 silently.
REQ-022 o_core_valid, o_core_ready and o_rsp_valid SHALL be driven from the registered state only (no combinational path from core or response inputs).
REQ-023 Minimum latency: accept -> o_core_valid is 1 cycle; accept -> o_rsp_valid is 1 cycle in bypass.
REQ-024 A requester deasserting i_req_valid while not granted SHALL lose nothing; arbitration uses only current-cycle i_req_valid.
REQ-025 i_core_valid outside WAIT SHALL be ignored.

Reset
REQ-026 While rst=1: state=IDLE, priority pointer=0, o_done_cnt=0, and o_req_ready, o_core_valid, o_core_ready, o_rsp_valid all 0. Data registers are cleared to 0.
REQ-027 Reset mid-transaction SHALL abandon the in-flight item with no response; the core is not flushed by this block.

Structure
REQ-028 Package gcd_sched_pkg SHALL hold the state enum, default NREQ/DW, and the ID-width localparam.
REQ-029 Sub-module rr_arbiter (NREQ-wide, request vector plus pointer in, one-hot grant plus index out) SHALL implement the REQ-016 priority.

Verification
REQ-030 Single request: req1 A=12, B=18, core model 3-cycle latency -> o_rsp_gcd=6, o_rsp_id=1, o_done_cnt=1.
REQ-031 All four valid continuously after reset -> grant order 0,1,2,3,0; each o_req_ready pulse is one cycle and one-hot.
REQ-032 Bypass: req2 A=0, B=9 -> o_rsp_valid one cycle after accept, gcd=9, o_core_valid never asserted; A=0, B=0 -> gcd=0.
REQ-033 Backpressure: i_core_ready low 5 cycles, then i_rsp_ready low 4 cycles -> o_core_a, o_core_b, o_rsp_gcd, o_rsp_id held stable; exactly one response.
REQ-034 rst pulsed during WAIT -> all outputs 0 next cycle; o_done_cnt=0; a new request A=15, B=10 then completes with 5.
REQ-035 Preload 0xFFFF completions by force, then one more -> o_done_cnt=0.
